id_ex_stage: RTL and testbench
==============================

ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed for MIPS32.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst_n  in  1  reset, synchronous and active-low.
REQ-004 stall  in  1  hold request from downstream; freezes the EX register.
REQ-005 flush  in  1  branch/jump squash; the next EX content becomes a bubble.
REQ-006 id_valid  in  1  the ID-stage instruction is real.
REQ-007 id_rs_data, id_rt_data  in  32 each  register-file read data.
REQ-008 id_imm  in  32  sign-extended immediate.
REQ-009 id_rs, id_rt, id_rd  in  5 each  source and destination register numbers.
REQ-010 id_alu_op  in  2  main-decoder ALU class; id_funct  in  6  R-type funct field.
REQ-011 id_ctrl  in  6  {alu_src, reg_dst, reg_write, mem_read, mem_write, mem_to_reg}.
REQ-012 exmem_reg_write  in  1, exmem_rd  in  5, exmem_result  in  32  EX/MEM forwarding source.
REQ-013 memwb_reg_write  in  1, memwb_rd  in  5, memwb_result  in  32  MEM/WB forwarding source.
REQ-014 alu_a, alu_b  out  32 each  ALU operands.
REQ-015 alu_ctrl  out  4  ALU operation code, registered.
REQ-016 ex_valid  out  1  the EX slot holds a real instruction.
REQ-017 ex_wr_reg  out  5  destination register; ex_store_data  out  32  forwarded rt data for stores.
REQ-018 ex_ctrl  out  4  {reg_write, mem_read, mem_write, mem_to_reg}.
REQ-019 load_use_stall  out  1  combinational hazard request to IF/ID.

Function
REQ-020 The EX register SHALL capture the ID inputs on the edge following their presentation, giving a latency of 1 cycle.
REQ-021 The EX register update priority SHALL be: !rst_n > flush > stall (hold all) > load_use_stall (insert bubble) > load.
REQ-022 A bubble SHALL set ex_valid=0, all ctrl bits=0, alu_ctrl=4'b0010, all data and register-number fields=0.
REQ-023 alu_ctrl decode on load SHALL be as follows. alu_op 00 gives 0010. alu_op 01 gives 0110. alu_op 11 gives 0010. For alu_op 10, funct selects the code: 100000 gives 0010, 100010 gives 0110, 100100 gives 0000, 100101 gives 0001, 101010 gives 0111, and any other funct gives 0010.
REQ-024 ex_wr_reg SHALL be captured as reg_dst ? id_rd : id_rt.
REQ-025 The forwarded rs value (fwdA) SHALL be taken from the first matching source, in priority order:
- exmem_result when exmem_reg_write && exmem_rd!=0 && exmem_rd==ex_rs;
- otherwise memwb_result when memwb_reg_write && memwb_rd!=0 && memwb_rd==ex_rs;
- otherwise the latched rs data.
REQ-026 The forwarded rt value (fwdB) SHALL follow the same rule as REQ-025, applied to ex_rt.
REQ-027 The forwarding paths SHALL be combinational: alu_a=fwdA; alu_b = alu_src ? latched imm : fwdB; ex_store_data=fwdB.
REQ-028 load_use_stall SHALL be 1 exactly when all of the following hold: ex_valid, ex mem_read, ex_rt!=0, id_valid, and (ex_rt==id_rs or ex_rt==id_rt).
REQ-029 Register 0 SHALL never forward or stall, even when a source reports rd=0 with reg_write=1.
REQ-030 While stall=1, all registered outputs SHALL remain unchanged, and the forwarded outputs SHALL still track the EX/MEM and MEM/WB inputs.

Reset
REQ-031 With rst_n=0 at a rising edge, the EX register SHALL take the bubble values of REQ-022, regardless of flush or stall.
REQ-032 Reset asserted mid-stall or mid-hazard SHALL clear the state in the same edge; load_use_stall SHALL be 0 on the following cycle.

Verification
REQ-033 Reset, then load add $3,$1,$2 (alu_op=10, funct=100000, rs=10, rt=20) -> the next cycle shows alu_ctrl=0010, alu_a=10, alu_b=20, ex_wr_reg=3, ex_valid=1.
REQ-034 Dual-source forwarding: ex_rs=1; exmem: rd=1, result=0x55, reg_write=1; memwb: rd=1, result=0x77, reg_write=1 -> alu_a=0x55; drop exmem_reg_write -> alu_a=0x77.
REQ-035 Register-0 guard: exmem rd=0, reg_write=1, ex_rs=0 -> no forwarding, alu_a equals the latched value.
REQ-036 Load-use: lw $5 in EX, then ID presents rs=5 -> load_use_stall=1; the next edge inserts a bubble (ex_valid=0, ex_ctrl=0).
REQ-037 flush and stall both 1 -> a bubble is inserted; stall alone for 3 cycles -> all registered outputs are held.
REQ-038 slt: alu_op=10, funct=101010, alu_src=0 -> alu_ctrl=0111; unknown funct 111111 -> alu_ctrl=0010.

Source files
------------

// File: rtl/id_ex_stage.sv
// MIPS32 ID/EX pipeline register with ALU-control decode, EX-stage operand
// forwarding from EX/MEM and MEM/WB, and load-use hazard detection.
module id_ex_stage (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        flush,
    input  logic        id_valid,
    input  logic [31:0] id_rs_data,
    input  logic [31:0] id_rt_data,
    input  logic [31:0] id_imm,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic [4:0]  id_rd,
    input  logic [1:0]  id_alu_op,
    input  logic [5:0]  id_funct,
    input  logic [5:0]  id_ctrl,
    input  logic        exmem_reg_write,
    input  logic [4:0]  exmem_rd,
    input  logic [31:0] exmem_result,
    input  logic        memwb_reg_write,
    input  logic [4:0]  memwb_rd,
    input  logic [31:0] memwb_result,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [3:0]  alu_ctrl,
    output logic        ex_valid,
    output logic [4:0]  ex_wr_reg,
    output logic [31:0] ex_store_data,
    output logic [3:0]  ex_ctrl,
    output logic        load_use_stall
);

    typedef struct packed {
        logic        valid;
        logic        alu_src;
        logic [3:0]  ctrl;      // {reg_write, mem_read, mem_write, mem_to_reg}
        logic [3:0]  alu_ctrl;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  wr_reg;
        logic [31:0] rs_data;
        logic [31:0] rt_data;
        logic [31:0] imm;
    } ex_reg_t;

    ex_reg_t ex_q;
    ex_reg_t ex_d;
    ex_reg_t bubble;
    logic [31:0] fwd_a;
    logic [31:0] fwd_b;

    function automatic logic [3:0] alu_decode(input logic [1:0] op, input logic [5:0] funct);
        logic [3:0] code;
        code = 4'b0010;
        case (op)
            2'b01: code = 4'b0110;
            2'b10: begin
                case (funct)
                    6'b100010: code = 4'b0110;
                    6'b100100: code = 4'b0000;
                    6'b100101: code = 4'b0001;
                    6'b101010: code = 4'b0111;
                    default:   code = 4'b0010;
                endcase
            end
            default: code = 4'b0010;
        endcase
        return code;
    endfunction

    // EX/MEM wins over MEM/WB since it holds the younger result; $0 never forwards.
    function automatic logic [31:0] fwd_sel(
        input logic [4:0]  r,
        input logic [31:0] latched,
        input logic        em_we,
        input logic [4:0]  em_rd,
        input logic [31:0] em_res,
        input logic        mw_we,
        input logic [4:0]  mw_rd,
        input logic [31:0] mw_res
    );
        logic [31:0] v;
        v = latched;
        if (em_we && em_rd != 5'd0 && em_rd == r)
            v = em_res;
        else if (mw_we && mw_rd != 5'd0 && mw_rd == r)
            v = mw_res;
        return v;
    endfunction

    always_comb begin
        bubble          = '0;
        bubble.alu_ctrl = 4'b0010;

        ex_d          = '0;
        ex_d.valid    = id_valid;
        ex_d.alu_src  = id_ctrl[5];
        ex_d.ctrl     = id_ctrl[3:0];
        ex_d.alu_ctrl = alu_decode(id_alu_op, id_funct);
        ex_d.rs       = id_rs;
        ex_d.rt       = id_rt;
        ex_d.wr_reg   = id_ctrl[4] ? id_rd : id_rt;
        ex_d.rs_data  = id_rs_data;
        ex_d.rt_data  = id_rt_data;
        ex_d.imm      = id_imm;
    end

    always_comb begin
        load_use_stall = ex_q.valid && ex_q.ctrl[2] && (ex_q.rt != 5'd0) && id_valid &&
                         ((ex_q.rt == id_rs) || (ex_q.rt == id_rt));
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            ex_q <= bubble;
        else if (flush)
            ex_q <= bubble;
        else if (stall)
            ex_q <= ex_q;
        else if (load_use_stall)
            ex_q <= bubble;
        else
            ex_q <= ex_d;
    end

    always_comb begin
        fwd_a = fwd_sel(ex_q.rs, ex_q.rs_data, exmem_reg_write, exmem_rd, exmem_result,
                        memwb_reg_write, memwb_rd, memwb_result);
        fwd_b = fwd_sel(ex_q.rt, ex_q.rt_data, exmem_reg_write, exmem_rd, exmem_result,
                        memwb_reg_write, memwb_rd, memwb_result);
    end

    assign alu_a         = fwd_a;
    assign alu_b         = ex_q.alu_src ? ex_q.imm : fwd_b;
    assign ex_store_data = fwd_b;
    assign alu_ctrl      = ex_q.alu_ctrl;
    assign ex_valid      = ex_q.valid;
    assign ex_wr_reg     = ex_q.wr_reg;
    assign ex_ctrl       = ex_q.ctrl;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: decode/latch vectors through a scoreboard queue,
// then directed sequences for forwarding, hazards, stall, flush and reset.
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        rst_n, stall, flush, id_valid;
    logic [31:0] id_rs_data, id_rt_data, id_imm;
    logic [4:0]  id_rs, id_rt, id_rd;
    logic [1:0]  id_alu_op;
    logic [5:0]  id_funct, id_ctrl;
    logic        exmem_reg_write, memwb_reg_write;
    logic [4:0]  exmem_rd, memwb_rd;
    logic [31:0] exmem_result, memwb_result;
    logic [31:0] alu_a, alu_b, ex_store_data;
    logic [3:0]  alu_ctrl, ex_ctrl;
    logic        ex_valid, load_use_stall;
    logic [4:0]  ex_wr_reg;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    id_ex_stage dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush), .id_valid(id_valid),
        .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .id_alu_op(id_alu_op), .id_funct(id_funct), .id_ctrl(id_ctrl),
        .exmem_reg_write(exmem_reg_write), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
        .memwb_reg_write(memwb_reg_write), .memwb_rd(memwb_rd), .memwb_result(memwb_result),
        .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl), .ex_valid(ex_valid),
        .ex_wr_reg(ex_wr_reg), .ex_store_data(ex_store_data), .ex_ctrl(ex_ctrl),
        .load_use_stall(load_use_stall)
    );

    typedef struct {
        logic [1:0]  op;
        logic [5:0]  funct;
        logic [5:0]  ctrl;
        logic [4:0]  rs, rt, rd;
        logic [31:0] rsd, rtd, imm;
        logic [3:0]  e_aluc;
        logic [31:0] e_a, e_b, e_st;
        logic [4:0]  e_wr;
        logic [3:0]  e_ctrl;
    } vec_t;

    typedef struct {
        logic [3:0]  aluc;
        logic [31:0] a, b, st;
        logic [4:0]  wr;
        logic [3:0]  ctrl;
    } exp_t;

    vec_t vecs[10];
    exp_t sb[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic v, input logic [1:0] op, input logic [5:0] funct,
                          input logic [5:0] ctrl, input logic [4:0] rs, input logic [4:0] rt,
                          input logic [4:0] rd, input logic [31:0] rsd, input logic [31:0] rtd,
                          input logic [31:0] imm);
        id_valid = v; id_alu_op = op; id_funct = funct; id_ctrl = ctrl;
        id_rs = rs; id_rt = rt; id_rd = rd;
        id_rs_data = rsd; id_rt_data = rtd; id_imm = imm;
    endtask

    task automatic clr_fwd;
        exmem_reg_write = 0; exmem_rd = 0; exmem_result = 0;
        memwb_reg_write = 0; memwb_rd = 0; memwb_result = 0;
    endtask

    initial begin
        exp_t e;
        // ctrl = {alu_src, reg_dst, reg_write, mem_read, mem_write, mem_to_reg}
        vecs[0] = '{2'b10, 6'h20, 6'b011000, 5'd1,  5'd2,  5'd3,  32'd10,     32'd20,     32'd0,
                    4'b0010, 32'd10,     32'd20,         32'd20,     5'd3,  4'b1000};
        vecs[1] = '{2'b10, 6'h22, 6'b011000, 5'd4,  5'd5,  5'd6,  32'd100,    32'd30,     32'd0,
                    4'b0110, 32'd100,    32'd30,         32'd30,     5'd6,  4'b1000};
        vecs[2] = '{2'b10, 6'h24, 6'b011000, 5'd1,  5'd2,  5'd7,  32'hF0F0,   32'h0FF0,   32'd0,
                    4'b0000, 32'hF0F0,   32'h0FF0,       32'h0FF0,   5'd7,  4'b1000};
        vecs[3] = '{2'b10, 6'h25, 6'b011000, 5'd1,  5'd2,  5'd8,  32'd1,      32'd2,      32'd0,
                    4'b0001, 32'd1,      32'd2,          32'd2,      5'd8,  4'b1000};
        vecs[4] = '{2'b10, 6'h2a, 6'b011000, 5'd1,  5'd2,  5'd9,  32'd5,      32'd9,      32'd0,
                    4'b0111, 32'd5,      32'd9,          32'd9,      5'd9,  4'b1000};
        vecs[5] = '{2'b10, 6'h3f, 6'b011000, 5'd1,  5'd2,  5'd10, 32'd6,      32'd4,      32'd0,
                    4'b0010, 32'd6,      32'd4,          32'd4,      5'd10, 4'b1000};
        vecs[6] = '{2'b00, 6'h00, 6'b101101, 5'd7,  5'd8,  5'd0,  32'h1000,   32'h99,     32'd4,
                    4'b0010, 32'h1000,   32'd4,          32'h99,     5'd8,  4'b1101};
        vecs[7] = '{2'b01, 6'h00, 6'b000000, 5'd9,  5'd10, 5'd11, 32'd7,      32'd7,      32'hFFFFFFFC,
                    4'b0110, 32'd7,      32'd7,          32'd7,      5'd10, 4'b0000};
        vecs[8] = '{2'b00, 6'h00, 6'b100010, 5'd11, 5'd12, 5'd0,  32'd200,    32'hCAFE,   32'hFFFFFFF8,
                    4'b0010, 32'd200,    32'hFFFFFFF8,   32'hCAFE,   5'd12, 4'b0010};
        vecs[9] = '{2'b11, 6'h22, 6'b101000, 5'd13, 5'd14, 5'd15, 32'd3,      32'h44,     32'd5,
                    4'b0010, 32'd3,      32'd5,          32'h44,     5'd14, 4'b1000};

        rst_n = 0; stall = 0; flush = 0;
        set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        clr_fwd();
        tick(); tick();
        chk("reset ex_valid", ex_valid, 0);
        chk("reset alu_ctrl", alu_ctrl, 4'b0010);
        chk("reset alu_a", alu_a, 0);
        chk("reset alu_b", alu_b, 0);
        chk("reset ex_wr_reg", ex_wr_reg, 0);
        chk("reset ex_ctrl", ex_ctrl, 0);
        chk("reset load_use_stall", load_use_stall, 0);
        rst_n = 1;

        for (int i = 0; i < 10; i++) begin
            set_id(1, vecs[i].op, vecs[i].funct, vecs[i].ctrl, vecs[i].rs, vecs[i].rt,
                   vecs[i].rd, vecs[i].rsd, vecs[i].rtd, vecs[i].imm);
            sb.push_back('{vecs[i].e_aluc, vecs[i].e_a, vecs[i].e_b, vecs[i].e_st,
                           vecs[i].e_wr, vecs[i].e_ctrl});
            #1 chk($sformatf("vec%0d no hazard", i), load_use_stall, 0);
            tick();
            if (sb.size() == 0) begin
                checks++; errors++;
                $display("FAIL vec%0d scoreboard empty", i);
            end else begin
                e = sb.pop_front();
                chk($sformatf("vec%0d ex_valid", i), ex_valid, 1);
                chk($sformatf("vec%0d alu_ctrl", i), alu_ctrl, e.aluc);
                chk($sformatf("vec%0d alu_a", i), alu_a, e.a);
                chk($sformatf("vec%0d alu_b", i), alu_b, e.b);
                chk($sformatf("vec%0d store", i), ex_store_data, e.st);
                chk($sformatf("vec%0d wr_reg", i), ex_wr_reg, e.wr);
                chk($sformatf("vec%0d ex_ctrl", i), ex_ctrl, e.ctrl);
            end
        end

        // Dual-source forwarding while the EX register is held
        set_id(1, 2'b10, 6'h20, 6'b011000, 5'd1, 5'd2, 5'd3, 32'h11, 32'h22, 0);
        tick();
        set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        stall = 1;
        exmem_reg_write = 1; exmem_rd = 1; exmem_result = 32'h55;
        memwb_reg_write = 1; memwb_rd = 1; memwb_result = 32'h77;
        #1 chk("fwd exmem over memwb", alu_a, 32'h55);
        exmem_reg_write = 0;
        #1 chk("fwd memwb", alu_a, 32'h77);
        memwb_reg_write = 0;
        #1 chk("fwd none", alu_a, 32'h11);
        exmem_reg_write = 1; exmem_rd = 2; exmem_result = 32'hAB;
        #1 chk("fwd b exmem", alu_b, 32'hAB);
        chk("fwd store exmem", ex_store_data, 32'hAB);
        exmem_rd = 3; memwb_reg_write = 1; memwb_rd = 2; memwb_result = 32'hCD;
        #1 chk("fwd b memwb", alu_b, 32'hCD);
        tick();
        chk("fwd stall held valid", ex_valid, 1);
        chk("fwd stall alu_a", alu_a, 32'h11);
        chk("fwd stall alu_b tracks", alu_b, 32'hCD);
        stall = 0;
        clr_fwd();

        // Register 0 never forwards
        set_id(1, 2'b00, 6'h00, 6'b001000, 5'd0, 5'd0, 5'd0, 32'h33, 32'h44, 0);
        tick();
        set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        exmem_reg_write = 1; exmem_rd = 0; exmem_result = 32'hDEAD;
        memwb_reg_write = 1; memwb_rd = 0; memwb_result = 32'hBEEF;
        #1 chk("r0 alu_a", alu_a, 32'h33);
        chk("r0 alu_b", alu_b, 32'h44);
        clr_fwd();

        // Load-use hazard: lw $5 in EX
        set_id(1, 2'b00, 6'h00, 6'b101101, 5'd3, 5'd5, 5'd0, 32'h100, 0, 32'd8);
        tick();
        set_id(0, 2'b10, 6'h20, 6'b011000, 5'd5, 5'd6, 5'd7, 1, 2, 0);
        #1 chk("lu id invalid", load_use_stall, 0);
        id_valid = 1;
        #1 chk("lu rs match", load_use_stall, 1);
        id_rs = 6; id_rt = 5;
        #1 chk("lu rt match", load_use_stall, 1);
        stall = 1;
        tick();
        chk("lu stall holds valid", ex_valid, 1);
        chk("lu stall holds ctrl", ex_ctrl, 4'b1101);
        chk("lu stall still hazard", load_use_stall, 1);
        stall = 0;
        tick();
        chk("lu bubble valid", ex_valid, 0);
        chk("lu bubble ctrl", ex_ctrl, 0);
        chk("lu bubble alu_ctrl", alu_ctrl, 4'b0010);
        chk("lu bubble wr_reg", ex_wr_reg, 0);
        chk("lu cleared", load_use_stall, 0);
        tick();
        chk("lu reissue valid", ex_valid, 1);
        set_id(1, 2'b00, 6'h00, 6'b101101, 5'd3, 5'd0, 5'd0, 0, 0, 0);
        tick();
        set_id(1, 2'b10, 6'h20, 6'b011000, 5'd0, 5'd0, 5'd1, 0, 0, 0);
        #1 chk("lu r0 no stall", load_use_stall, 0);

        // Flush beats stall
        set_id(1, 2'b10, 6'h20, 6'b011000, 5'd1, 5'd2, 5'd3, 1, 2, 0);
        tick();
        chk("flush pre valid", ex_valid, 1);
        flush = 1; stall = 1;
        tick();
        chk("flush+stall valid", ex_valid, 0);
        chk("flush+stall ctrl", ex_ctrl, 0);
        flush = 0; stall = 0;

        // Three-cycle stall holds registered outputs
        set_id(1, 2'b10, 6'h22, 6'b011000, 5'd4, 5'd5, 5'd9, 32'd7, 32'd3, 0);
        tick();
        set_id(1, 2'b10, 6'h24, 6'b011000, 5'd1, 5'd2, 5'd20, 32'd70, 32'd30, 0);
        stall = 1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk($sformatf("stall%0d alu_ctrl", k), alu_ctrl, 4'b0110);
            chk($sformatf("stall%0d wr_reg", k), ex_wr_reg, 5'd9);
            chk($sformatf("stall%0d alu_a", k), alu_a, 32'd7);
            chk($sformatf("stall%0d alu_b", k), alu_b, 32'd3);
            chk($sformatf("stall%0d valid", k), ex_valid, 1);
        end
        stall = 0;
        tick();
        chk("post stall alu_ctrl", alu_ctrl, 4'b0000);
        chk("post stall wr_reg", ex_wr_reg, 5'd20);

        // Reset mid-stall with a pending hazard
        set_id(1, 2'b00, 6'h00, 6'b101101, 5'd3, 5'd5, 5'd0, 0, 0, 0);
        tick();
        set_id(1, 2'b10, 6'h20, 6'b011000, 5'd5, 5'd1, 5'd2, 0, 0, 0);
        stall = 1;
        #1 chk("rst pre hazard", load_use_stall, 1);
        rst_n = 0;
        tick();
        chk("rst mid valid", ex_valid, 0);
        chk("rst mid ctrl", ex_ctrl, 0);
        chk("rst mid hazard", load_use_stall, 0);
        rst_n = 1; stall = 0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
